prog1_sequencer: RTL

Upstream/downstream harness stage for the program-1 core (min & max Hamming distance over 32 16-bit operands). Accepts a 64-byte operand stream and writes it into data memory [0:63]. Presets the result area: [64]=16, [65:255]=0. Launches the core through its start/done handshake, then reads back the Min ([64]) and Max ([65]) results and reports them with a one-cycle valid pulse. Owns the data-memory write/read port whenever the core is not running.

---
 rtl/prog1_pkg.sv | 28 ++
 rtl/prog1_sequencer_if.sv | 34 +++
 rtl/prog1_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/prog1_pkg.sv
// Shared types and constants for the program-1 harness sequencer.
// Result layout in data memory and the sequencer state encoding live here.
package prog1_pkg;

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        PRESET,
        LAUNCH,
        GUARD,
        WAIT,
        READ_MIN,
        READ_MAX,
        REPORT
    } seq_state_t;

    localparam int         DATA_W   = 8;
    localparam int         RES_W    = 5;
    localparam logic [7:0] MIN_ADDR = 8'd64;
    localparam logic [7:0] MAX_ADDR = 8'd65;
    localparam logic [7:0] HAM_MAX  = 8'd16;

    // Min starts at the largest legal distance, everything else in the result area at zero.
    function automatic logic [7:0] preset_value(input logic [7:0] addr);
        return (addr == MIN_ADDR) ? HAM_MAX : 8'd0;
    endfunction

endpackage

// File: rtl/prog1_sequencer_if.sv
// Operand stream, data-memory port, core handshake and result signals of the sequencer.
// master is the sequencer's view, slave is the surrounding harness.
interface prog1_sequencer_if;
    import prog1_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_byte;
    logic              mem_sel;
    logic              mem_wr_en;
    logic [7:0]        mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;
    logic              dut_start;
    logic              dut_done;
    logic              busy;
    logic              res_valid;
    logic [RES_W-1:0]  min_dist;
    logic [RES_W-1:0]  max_dist;
    logic              res_err;

    modport master (
        input  in_valid, in_byte, mem_rd_data, dut_done,
        output in_ready, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
               dut_start, busy, res_valid, min_dist, max_dist, res_err
    );

    modport slave (
        output in_valid, in_byte, mem_rd_data, dut_done,
        input  in_ready, mem_sel, mem_wr_en, mem_addr, mem_wr_data,
               dut_start, busy, res_valid, min_dist, max_dist, res_err
    );

endinterface

// File: rtl/prog1_sequencer.sv
// Loads the operand stream, presets the result area, runs the core and reports Min/Max.
// All memory-port and handshake outputs are registered; busy/res_valid/res_err decode the state.
module prog1_sequencer
    import prog1_pkg::*;
#(
    parameter int NUM_OPS    = 32,
    parameter int DONE_GUARD = 2,
    parameter int TIMEOUT    = 65535
) (
    input logic               clk,
    input logic               reset,
    prog1_sequencer_if.master bus
);

    localparam logic [7:0]  LAST_BYTE  = 8'(2 * NUM_OPS - 1);
    localparam logic [15:0] GUARD_LAST = 16'(DONE_GUARD - 1);
    localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT - 1);

    seq_state_t  state, state_d;
    logic [7:0]  cnt, cnt_d;
    logic [15:0] tcnt, tcnt_d;
    logic        in_ready_q, in_ready_d;
    logic        mem_sel_q, mem_sel_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        dut_start_q, dut_start_d;
    logic [7:0]  min_q, min_d;
    logic [7:0]  max_q, max_d;
    logic        tout_q, tout_d;
    logic        xfer;

    // Full result bytes are kept so out-of-range values are caught before truncation.
    function automatic logic result_bad(input logic [7:0] mn, input logic [7:0] mx);
        return (mn > HAM_MAX) || (mx > HAM_MAX) || (mn > mx);
    endfunction

    assign xfer = bus.in_valid & in_ready_q;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        tcnt_d      = tcnt;
        in_ready_d  = in_ready_q;
        mem_sel_d   = mem_sel_q;
        wr_en_d     = 1'b0;
        addr_d      = addr_q;
        wr_data_d   = wr_data_q;
        dut_start_d = dut_start_q;
        min_d       = min_q;
        max_d       = max_q;
        tout_d      = tout_q;
        case (state)
            IDLE: begin
                in_ready_d = 1'b1;
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    addr_d    = cnt;
                    wr_data_d = bus.in_byte;
                    cnt_d     = cnt + 8'd1;
                    tout_d    = 1'b0;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    addr_d    = cnt;
                    wr_data_d = bus.in_byte;
                    cnt_d     = cnt + 8'd1;
                    if (cnt == LAST_BYTE) begin
                        in_ready_d = 1'b0;
                        cnt_d      = MIN_ADDR;
                        state_d    = PRESET;
                    end
                end
            end
            PRESET: begin
                wr_en_d   = 1'b1;
                addr_d    = cnt;
                wr_data_d = preset_value(cnt);
                cnt_d     = cnt + 8'd1;
                if (cnt == 8'hFF) state_d = LAUNCH;
            end
            LAUNCH: begin
                mem_sel_d   = 1'b0;
                dut_start_d = 1'b0;
                tcnt_d      = 16'd0;
                state_d     = GUARD;
            end
            GUARD: begin
                tcnt_d = tcnt + 16'd1;
                if (tcnt == GUARD_LAST) begin
                    tcnt_d  = 16'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.dut_done) begin
                    mem_sel_d = 1'b1;
                    addr_d    = MIN_ADDR;
                    state_d   = READ_MIN;
                end else if (tcnt == WAIT_LAST) begin
                    // Abort: reclaim memory and stop the core; previous results stay on the outputs.
                    tout_d      = 1'b1;
                    mem_sel_d   = 1'b1;
                    dut_start_d = 1'b1;
                    state_d     = REPORT;
                end else begin
                    tcnt_d = tcnt + 16'd1;
                end
            end
            READ_MIN: begin
                min_d   = bus.mem_rd_data;
                addr_d  = MAX_ADDR;
                state_d = READ_MAX;
            end
            READ_MAX: begin
                max_d       = bus.mem_rd_data;
                dut_start_d = 1'b1;
                state_d     = REPORT;
            end
            REPORT: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            tcnt        <= 16'd0;
            in_ready_q  <= 1'b0;
            mem_sel_q   <= 1'b1;
            wr_en_q     <= 1'b0;
            addr_q      <= 8'd0;
            wr_data_q   <= 8'd0;
            dut_start_q <= 1'b1;
            min_q       <= 8'd0;
            max_q       <= 8'd0;
            tout_q      <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            tcnt        <= tcnt_d;
            in_ready_q  <= in_ready_d;
            mem_sel_q   <= mem_sel_d;
            wr_en_q     <= wr_en_d;
            addr_q      <= addr_d;
            wr_data_q   <= wr_data_d;
            dut_start_q <= dut_start_d;
            min_q       <= min_d;
            max_q       <= max_d;
            tout_q      <= tout_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.mem_sel     = mem_sel_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.dut_start   = dut_start_q;
    assign bus.busy        = (state != IDLE);
    assign bus.res_valid   = (state == REPORT);
    assign bus.res_err     = (state == REPORT) && (tout_q || result_bad(min_q, max_q));
    assign bus.min_dist    = min_q[RES_W-1:0];
    assign bus.max_dist    = max_q[RES_W-1:0];

endmodule
